// File: rtl/join_alu_stage.sv
`timescale 1ns/1ps
// Purpose : elastic 16-op ALU stage behind the CGRA join; two-slot skid buffer, registered result.
// Latency : 1 cycle from accept to io_dout_v (buffer EMPTY, or ONE with a simultaneous output transfer).
// Backpr. : io_din_r is a pure register bit (!skid_v); at most one extra pair is absorbed after io_dout_r drops.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   io_din_1/_2/_v, io_din_r operand pair channel from the join (A, B, valid, ready)
//   io_op                   operation select, sampled on the accept cycle
//   io_dout/_v, io_dout_r   result channel (data, valid, downstream ready)
//   io_count                results delivered downstream, wraps at 2^CNT_WIDTH
module join_alu_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] io_din_1,
  input  logic [DATA_WIDTH-1:0] io_din_2,
  input  logic                  io_din_v,
  output logic                  io_din_r,
  input  logic [3:0]            io_op,
  output logic [DATA_WIDTH-1:0] io_dout,
  output logic                  io_dout_v,
  input  logic                  io_dout_r,
  output logic [CNT_WIDTH-1:0]  io_count
);

  localparam int SHW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Encoding chosen so that bit0 is main_v and bit1 is skid_v: both valid
  // flags, and therefore io_din_r, come straight off flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_t;

  occ_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0] main_d, skid_d, res;
  logic                  main_v, skid_v;
  logic                  fire_in, fire_out;
  logic                  load_main_res, load_main_skid, load_skid;
  logic [CNT_WIDTH-1:0]  count;

  logic [SHW-1:0]          shamt;
  logic [2*DATA_WIDTH-1:0] prod;

  assign main_v    = state[0];
  assign skid_v    = state[1];
  assign io_din_r  = !skid_v;
  assign io_dout   = main_d;
  assign io_dout_v = main_v;
  assign io_count  = count;

  assign fire_in  = io_din_v & io_din_r;
  assign fire_out = main_v & io_dout_r;

  // ---------------- ALU ----------------
  assign shamt = io_din_2[SHW-1:0];
  assign prod  = {{DATA_WIDTH{1'b0}}, io_din_1} * {{DATA_WIDTH{1'b0}}, io_din_2};

  always_comb begin
    res = '0;
    case (io_op)
      4'd0:  res = io_din_1 + io_din_2;
      4'd1:  res = io_din_1 - io_din_2;
      4'd2:  res = prod[DATA_WIDTH-1:0];
      4'd3:  res = io_din_1 & io_din_2;
      4'd4:  res = io_din_1 | io_din_2;
      4'd5:  res = io_din_1 ^ io_din_2;
      4'd6:  res = io_din_1 << shamt;
      4'd7:  res = io_din_1 >> shamt;
      4'd8:  res = $signed(io_din_1) >>> shamt;
      4'd9:  res = DATA_WIDTH'(io_din_1 == io_din_2);
      4'd10: res = DATA_WIDTH'(io_din_1 < io_din_2);
      4'd11: res = DATA_WIDTH'($signed(io_din_1) < $signed(io_din_2));
      4'd12: res = (io_din_1 < io_din_2) ? io_din_1 : io_din_2;
      4'd13: res = (io_din_1 < io_din_2) ? io_din_2 : io_din_1;
      4'd14: res = io_din_1;
      4'd15: res = io_din_2;
      default: res = '0;
    endcase
  end

  // ---------------- occupancy FSM ----------------
  always_comb begin
    state_nxt      = state;
    load_main_res  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (fire_in) begin
          load_main_res = 1'b1;
          state_nxt     = ONE;
        end
      end
      ONE: begin
        if (fire_in && fire_out) begin
          load_main_res = 1'b1;
        end else if (fire_in) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (fire_out) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // io_din_r is low here, so only the output side can move.
        if (fire_out) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= EMPTY;
      main_d <= '0;
      skid_d <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_res)       main_d <= res;
      else if (load_main_skid) main_d <= skid_d;
      if (load_skid)           skid_d <= res;
      if (fire_out)            count  <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_join_alu_stage.sv
`timescale 1ns/1ps
module tb_join_alu_stage;

  logic       clock;
  logic       reset;
  logic [7:0] io_din_1, io_din_2, io_dout;
  logic       io_din_v, io_din_r, io_dout_v, io_dout_r;
  logic [3:0] io_op;
  logic [3:0] io_count;

  join_alu_stage #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .io_din_1  (io_din_1),
    .io_din_2  (io_din_2),
    .io_din_v  (io_din_v),
    .io_din_r  (io_din_r),
    .io_op     (io_op),
    .io_dout   (io_dout),
    .io_dout_v (io_dout_v),
    .io_dout_r (io_dout_r),
    .io_count  (io_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [3:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one pair and hold it until accepted; the expected result is queued at acceptance.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] e);
    int waits = 0;
    io_din_1 = a;
    io_din_2 = b;
    io_op    = op;
    io_din_v = 1'b1;
    forever begin
      @(negedge clock);
      if (io_din_r) begin
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        return;
      end
      @(posedge clock);
      #1;
      waits++;
      if (waits > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: io_din_r stayed 0, expected 1 within 50 cycles");
        io_din_v = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #1;
      if (exp_q.size() == 0) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
  endtask

  // Monitor: compares every delivered result against the scoreboard and checks stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d     = '0;
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'd0, io_dout_v}, 32'd1);
          check("stall_data", {24'd0, io_dout}, {24'd0, prev_d});
        end
        if (io_dout_v && io_dout_r) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got 0x%0h, expected no output", io_dout);
          end else begin
            check("dout", {24'd0, io_dout}, {24'd0, exp_q.pop_front()});
          end
        end
        prev_stall = io_dout_v && !io_dout_r;
        prev_d     = io_dout;
      end
    end
  end

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e;
  } vec_t;

  vec_t sweep[17] = '{
    {4'd1,  8'h05, 8'h07, 8'hFE},  // SUB wraps
    {4'd2,  8'h13, 8'h11, 8'h43},  // MUL low byte of 0x143
    {4'd3,  8'hF0, 8'h3C, 8'h30},  // AND
    {4'd4,  8'hF0, 8'h0F, 8'hFF},  // OR
    {4'd5,  8'hAA, 8'hFF, 8'h55},  // XOR
    {4'd6,  8'h81, 8'h09, 8'h02},  // SHL, only B[2:0]=1 used
    {4'd7,  8'h80, 8'h03, 8'h10},  // SHR
    {4'd8,  8'h80, 8'h03, 8'hF0},  // ASR
    {4'd9,  8'h5A, 8'h5A, 8'h01},  // EQ true
    {4'd9,  8'h5A, 8'h5B, 8'h00},  // EQ false
    {4'd10, 8'hFF, 8'h01, 8'h00},  // LTU
    {4'd11, 8'hFF, 8'h01, 8'h01},  // LTS -1 < 1
    {4'd11, 8'h01, 8'hFF, 8'h00},  // LTS 1 < -1 false
    {4'd12, 8'h7F, 8'h80, 8'h7F},  // MIN
    {4'd13, 8'h7F, 8'h80, 8'h80},  // MAX
    {4'd14, 8'h12, 8'h34, 8'h12},  // PASSA
    {4'd15, 8'h12, 8'h34, 8'h34}   // PASSB
  };

  logic din_r_exp[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    time t0;
    reset     = 1'b1;
    io_din_v  = 1'b0;
    io_din_1  = '0;
    io_din_2  = '0;
    io_op     = '0;
    io_dout_r = 1'b0;
    exp_cnt   = '0;

    // Reset / idle
    @(negedge clock);
    check("rst_dout_v", {31'd0, io_dout_v}, 32'd0);
    check("rst_din_r", {31'd0, io_din_r}, 32'd1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("idle_dout_v", {31'd0, io_dout_v}, 32'd0);
    check("idle_dout", {24'd0, io_dout}, 32'h00);
    check("idle_din_r", {31'd0, io_din_r}, 32'd1);
    check("idle_count", {28'd0, io_count}, 32'd0);
    @(posedge clock);
    #1;

    // Single ADD with one-cycle latency
    io_dout_r = 1'b1;
    send(4'd0, 8'hF0, 8'h20, 8'h10);
    io_din_v = 1'b0;
    check("add_lat_v", {31'd0, io_dout_v}, 32'd1);
    check("add_lat_d", {24'd0, io_dout}, 32'h10);
    drain();
    exp_cnt = exp_cnt + 4'd1;
    check("add_count", {28'd0, io_count}, {28'd0, exp_cnt});

    // Opcode sweep streamed back to back
    t0 = $time;
    for (int i = 0; i < 17; i++) send(sweep[i].op, sweep[i].a, sweep[i].b, sweep[i].e);
    check("sweep_rate", 32'($time - t0), 32'd170);
    io_din_v = 1'b0;
    drain();
    exp_cnt = exp_cnt + 4'd1;  // 17 more results: 4-bit count advances by 1 mod 16
    check("sweep_count", {28'd0, io_count}, {28'd0, exp_cnt});

    // Backpressure: stall downstream cycles 1..4
    fork
      begin
        send(4'd1, 8'd5, 8'd1, 8'd4);
        send(4'd1, 8'd9, 8'd2, 8'd7);
        send(4'd1, 8'd7, 8'd7, 8'd0);
        io_din_v = 1'b0;
      end
      begin
        io_dout_r = 1'b1;
        @(posedge clock);
        #1 io_dout_r = 1'b0;
        repeat (4) @(posedge clock);
        #1 io_dout_r = 1'b1;
      end
      begin
        for (int c = 0; c < 8; c++) begin
          @(negedge clock);
          check($sformatf("bp_din_r_c%0d", c), {31'd0, io_din_r}, {31'd0, din_r_exp[c]});
        end
      end
    join
    drain();
    exp_cnt = exp_cnt + 4'd3;
    check("bp_count", {28'd0, io_count}, {28'd0, exp_cnt});

    // Reset while FULL
    io_dout_r = 1'b0;
    send(4'd0, 8'h01, 8'h01, 8'h02);
    send(4'd0, 8'h02, 8'h02, 8'h04);
    io_din_v = 1'b0;
    check("full_din_r", {31'd0, io_din_r}, 32'd0);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    check("mrst_dout_v", {31'd0, io_dout_v}, 32'd0);
    check("mrst_din_r", {31'd0, io_din_r}, 32'd1);
    check("mrst_count", {28'd0, io_count}, 32'd0);
    io_dout_r = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("mrst_quiet", {31'd0, io_dout_v}, 32'd0);

    // Counter wrap: 17 results continuously on a 4-bit counter
    t0 = $time;
    for (int i = 0; i < 17; i++) send(4'd0, 8'(i), 8'h01, 8'(i + 1));
    check("wrap_rate", 32'($time - t0), 32'd170);
    io_din_v = 1'b0;
    drain();
    check("wrap_count", {28'd0, io_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/join_alu_stage.md
# join_alu_stage

Elastic two-operand function stage that consumes the paired operands produced by the CGRA join stage and returns a registered result on a valid/ready channel. It applies one of sixteen ALU operations selected by `io_op`. A two-entry skid buffer keeps full throughput while registering `io_din_r`, which breaks the combinational ready chain that runs back through the join into both producers.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of both operands and of the result.
- `CNT_WIDTH`, default 16: width of the result counter.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_din_1`  in  DATA_WIDTH  operand A; driven by the join's `io_dout_1`.
- `io_din_2`  in  DATA_WIDTH  operand B; driven by the join's `io_dout_2`.
- `io_din_v`  in  1  operand pair valid; driven by the join's `io_dout_v`.
- `io_din_r`  out  1  stage ready; drives the join's `io_dout_r`.
- `io_op`  in  4  operation select, sampled on the accept cycle.
- `io_dout`  out  DATA_WIDTH  result.
- `io_dout_v`  out  1  result valid.
- `io_dout_r`  in  1  downstream ready.
- `io_count`  out  CNT_WIDTH  number of results delivered downstream.

## Operation
- Definitions:
  - fire_in = `io_din_v & io_din_r`.
  - fire_out = `io_dout_v & io_dout_r`.
  - res = f(`io_op`, A, B), computed combinationally from the current inputs.
- Storage:
  - main slot: main_v, main_d.
  - skid slot: skid_v, skid_d.
- Output mapping:
  - `io_dout` = main_d.
  - `io_dout_v` = main_v.
  - `io_din_r` = !skid_v. This is a pure register output with no combinational path from `io_dout_r` or `io_din_v`.
- Buffer occupancy states (main_v, skid_v):
  - EMPTY (0,0)
  - ONE (1,0)
  - FULL (1,1)
  - (0,1) is illegal and never reached.
- Transitions, one per cycle:
  - EMPTY, fire_in: main_d ← res, go to ONE.
  - ONE, fire_in & fire_out: main_d ← res, stay in ONE.
  - ONE, fire_in & !fire_out: skid_d ← res, go to FULL.
  - ONE, !fire_in & fire_out: go to EMPTY.
  - FULL, fire_out: main_d ← skid_d, go to ONE. fire_in is impossible here because `io_din_r`=0.
  - All other cases: hold.
- Opcodes. Shift amount is B[log2(DATA_WIDTH)-1:0]. Compare results are zero-extended 0/1.
  - 0 ADD: A+B, modulo 2^W.
  - 1 SUB: A−B, modulo 2^W.
  - 2 MUL: low W bits of A*B.
  - 3 AND, 4 OR, 5 XOR.
  - 6 SHL: logical shift left.
  - 7 SHR: logical shift right.
  - 8 ASR: arithmetic shift right.
  - 9 EQ: A==B.
  - 10 LTU: A<B unsigned.
  - 11 LTS: A<B signed.
  - 12 MIN: unsigned minimum.
  - 13 MAX: unsigned maximum.
  - 14 PASSA: A.
  - 15 PASSB: B.
- Arithmetic:
  - Carries and overflow are discarded; there is no flag output.
  - `io_op` is a per-transfer input. Changing it between transfers takes effect on the next accepted pair.
- Counter:
  - `io_count` increments by 1 on every fire_out.
  - Wraps from 2^CNT_WIDTH−1 to 0.

## Timing
- Reset values: main_v=0, skid_v=0, main_d=0, skid_d=0, `io_count`=0.
- Resulting outputs while `reset`=1 and on the first cycle after it is released:
  - `io_dout_v`=0, `io_dout`=0.
  - `io_din_r`=1.
- Reset asserted mid-operation discards both slots on the next edge. In-flight results are lost and are not counted.
- Latency: an operand pair accepted at edge N is visible on `io_dout` with `io_dout_v`=1 after edge N (cycle N+1). This holds when the buffer was EMPTY, or ONE with simultaneous fire_out.
- Throughput: one result per cycle while `io_dout_r`=1 is held.
- Backpressure:
  - After `io_dout_r` drops, at most one further pair is accepted (into the skid slot).
  - `io_din_r` falls on the following edge.
- Refill: FULL with fire_out returns to ONE, and `io_din_r` returns to 1 on the next cycle.
- Ordering: results leave in strict acceptance order with no loss or duplication.
- Stability: while `io_dout_v`=1 and `io_dout_r`=0, `io_dout` and `io_dout_v` hold unchanged.
- Once valid is raised it is never withdrawn without fire_out, except by reset.

## Test plan
- Reset/idle: hold `reset` for 2 cycles, then release with `io_din_v`=0.
  - Required: `io_dout_v`=0, `io_dout`=0x00, `io_din_r`=1, `io_count`=0.
- Single ADD: apply A=0xF0, B=0x20, op=0 with `io_dout_r`=1.
  - Required: next cycle `io_dout`=0x10 and `io_dout_v`=1.
  - Required: `io_count`=1 after the transfer.
- Opcode sweep, W=8:
  - MUL 0x13*0x11 → 0x43.
  - ASR 0x80,3 → 0xF0.
  - LTS 0xFF,0x01 → 1.
  - LTU 0xFF,0x01 → 0.
  - MAX 0x7F,0x80 → 0x80.
- Backpressure: stream SUB pairs (5,1),(9,2),(7,7) every cycle; hold `io_dout_r`=0 from the second cycle for 4 cycles, then raise it.
  - Required: `io_din_r` low exactly while FULL.
  - Required: outputs are 4, 7, 0 in order, with no drops.
  - Required: `io_dout` stable while stalled.
- Reset mid-stream: reset while FULL.
  - Required: `io_dout_v`=0 and `io_din_r`=1 the next cycle; `io_count`=0.
  - Required: the old results never appear on `io_dout`.
- Counter wrap: with CNT_WIDTH=4, deliver 17 results continuously.
  - Required: `io_count` reads 1; throughput is 1 result per cycle.
